// File: rtl/mcdt.sv
// Multi-channel data transfer: three valid/ready write channels, each with its own FIFO,
// merged onto one output stream by a round-robin arbiter. Each output word is tagged with its channel ID.
module mcdt #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [DATA_W-1:0] ch0_data_i,
  input  logic              ch0_valid_i,
  output logic              ch0_ready_o,
  output logic [5:0]        ch0_margin_o,
  input  logic [DATA_W-1:0] ch1_data_i,
  input  logic              ch1_valid_i,
  output logic              ch1_ready_o,
  output logic [5:0]        ch1_margin_o,
  input  logic [DATA_W-1:0] ch2_data_i,
  input  logic              ch2_valid_i,
  output logic              ch2_ready_o,
  output logic [5:0]        ch2_margin_o,
  output logic [DATA_W-1:0] mcdt_data_o,
  output logic              mcdt_val_o,
  output logic [1:0]        mcdt_id_o
);

  localparam int         NCH     = 3;
  localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [5:0] DEPTH_C = 6'(FIFO_DEPTH);

  logic [DATA_W-1:0] in_data_s [NCH];
  logic [NCH-1:0]    in_valid_s;
  logic [NCH-1:0]    push_s;
  logic [NCH-1:0]    pop_s;
  logic [NCH-1:0]    non_empty_s;

  logic [DATA_W-1:0] mem_r    [NCH][FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r [NCH];
  logic [AW-1:0]     rd_ptr_r [NCH];
  logic [5:0]        cnt_r    [NCH];

  logic [1:0]        last_r;
  logic [1:0]        ord0_s;
  logic [1:0]        ord1_s;
  logic [1:0]        ord2_s;
  logic [1:0]        gnt_id_s;
  logic              gnt_valid_s;
  logic [DATA_W-1:0] rd_data_s;

  assign in_data_s[0] = ch0_data_i;
  assign in_data_s[1] = ch1_data_i;
  assign in_data_s[2] = ch2_data_i;
  assign in_valid_s   = {ch2_valid_i, ch1_valid_i, ch0_valid_i};

  // Ready and margin come straight from the registered counts so they read full depth during reset.
  assign ch0_ready_o  = (cnt_r[0] < DEPTH_C);
  assign ch1_ready_o  = (cnt_r[1] < DEPTH_C);
  assign ch2_ready_o  = (cnt_r[2] < DEPTH_C);
  assign ch0_margin_o = DEPTH_C - cnt_r[0];
  assign ch1_margin_o = DEPTH_C - cnt_r[1];
  assign ch2_margin_o = DEPTH_C - cnt_r[2];

  // Per-channel FIFO status and write acceptance
  always_comb begin
    non_empty_s = '0;
    push_s      = '0;
    for (int i = 0; i < NCH; i++) begin
      non_empty_s[i] = (cnt_r[i] != 6'd0);
      push_s[i]      = in_valid_s[i] && (cnt_r[i] < DEPTH_C);
    end
  end

  // Round-robin search order starting at the channel after the last grant
  always_comb begin
    case (last_r)
      2'd0: begin
        ord0_s = 2'd1;
        ord1_s = 2'd2;
        ord2_s = 2'd0;
      end
      2'd1: begin
        ord0_s = 2'd2;
        ord1_s = 2'd0;
        ord2_s = 2'd1;
      end
      default: begin
        ord0_s = 2'd0;
        ord1_s = 2'd1;
        ord2_s = 2'd2;
      end
    endcase
  end

  // Grant the first non-empty channel in search order
  always_comb begin
    gnt_valid_s = |non_empty_s;
    if (non_empty_s[ord0_s]) begin
      gnt_id_s = ord0_s;
    end else if (non_empty_s[ord1_s]) begin
      gnt_id_s = ord1_s;
    end else if (non_empty_s[ord2_s]) begin
      gnt_id_s = ord2_s;
    end else begin
      gnt_id_s = 2'd0;
    end
  end

  // One-hot pop strobe for the granted FIFO
  always_comb begin
    pop_s = '0;
    for (int i = 0; i < NCH; i++) begin
      pop_s[i] = gnt_valid_s && (gnt_id_s == 2'(i));
    end
  end

  // Head-of-queue read mux for the granted channel
  always_comb begin
    case (gnt_id_s)
      2'd1:    rd_data_s = mem_r[1][rd_ptr_r[1]];
      2'd2:    rd_data_s = mem_r[2][rd_ptr_r[2]];
      default: rd_data_s = mem_r[0][rd_ptr_r[0]];
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NCH; i++) begin
      if (push_s[i]) begin
        mem_r[i][wr_ptr_r[i]] <= in_data_s[i];
      end
    end
  end

  // FIFO pointers and occupancy counts
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NCH; i++) begin
        wr_ptr_r[i] <= '0;
        rd_ptr_r[i] <= '0;
        cnt_r[i]    <= 6'd0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (push_s[i]) begin
          wr_ptr_r[i] <= wr_ptr_r[i] + AW'(1);
        end
        if (pop_s[i]) begin
          rd_ptr_r[i] <= rd_ptr_r[i] + AW'(1);
        end
        case ({push_s[i], pop_s[i]})
          2'b10:   cnt_r[i] <= cnt_r[i] + 6'd1;
          2'b01:   cnt_r[i] <= cnt_r[i] - 6'd1;
          default: cnt_r[i] <= cnt_r[i];
        endcase
      end
    end
  end

  // Arbiter pointer and output register; last_r=2 makes channel 0 first after reset
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      last_r      <= 2'd2;
      mcdt_val_o  <= 1'b0;
      mcdt_data_o <= '0;
      mcdt_id_o   <= 2'd0;
    end else if (gnt_valid_s) begin
      last_r      <= gnt_id_s;
      mcdt_val_o  <= 1'b1;
      mcdt_data_o <= rd_data_s;
      mcdt_id_o   <= gnt_id_s;
    end else begin
      mcdt_val_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mcdt.sv
// Self-checking bench for mcdt: a hand-computed vector table plus model-checked multi-cycle sequences.
module tb_mcdt;

  logic        clk;
  logic        rstn;
  logic [31:0] ch0_data, ch1_data, ch2_data;
  logic        ch0_valid, ch1_valid, ch2_valid;
  logic        ch0_ready, ch1_ready, ch2_ready;
  logic [5:0]  ch0_margin, ch1_margin, ch2_margin;
  logic [31:0] mcdt_data;
  logic        mcdt_val;
  logic [1:0]  mcdt_id;

  int tests  = 0;
  int failed = 0;

  mcdt dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .ch0_data_i   (ch0_data),
    .ch0_valid_i  (ch0_valid),
    .ch0_ready_o  (ch0_ready),
    .ch0_margin_o (ch0_margin),
    .ch1_data_i   (ch1_data),
    .ch1_valid_i  (ch1_valid),
    .ch1_ready_o  (ch1_ready),
    .ch1_margin_o (ch1_margin),
    .ch2_data_i   (ch2_data),
    .ch2_valid_i  (ch2_valid),
    .ch2_ready_o  (ch2_ready),
    .ch2_margin_o (ch2_margin),
    .mcdt_data_o  (mcdt_data),
    .mcdt_val_o   (mcdt_val),
    .mcdt_id_o    (mcdt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  v;
    logic [31:0] d0, d1, d2;
    logic        ev;
    logic [1:0]  eid;
    logic [31:0] ed;
    logic [5:0]  m0, m1, m2;
  } vec_t;

  vec_t tbl [13];

  // Reference model: per-channel queues, round-robin pointer, expected output register
  logic [31:0] q0[$], q1[$], q2[$];
  int          m_last;
  logic        m_val;
  logic [1:0]  m_id;
  logic [31:0] m_data;
  int          strobes0;
  int          strobes_any;
  bit          saw_full;

  function automatic int qsize(int c);
    case (c)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [31:0] qpop(int c);
    case (c)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic check_model(input string name);
    logic [5:0] e0, e1, e2;
    e0 = 6'(32 - q0.size());
    e1 = 6'(32 - q1.size());
    e2 = 6'(32 - q2.size());
    tests++;
    if (mcdt_val !== m_val || mcdt_id !== m_id || mcdt_data !== m_data) begin
      failed++;
      $display("FAIL %s out: got val=%0b id=%0d data=%h, expected val=%0b id=%0d data=%h",
               name, mcdt_val, mcdt_id, mcdt_data, m_val, m_id, m_data);
    end
    tests++;
    if ({ch0_margin, ch1_margin, ch2_margin} !== {e0, e1, e2} ||
        {ch0_ready, ch1_ready, ch2_ready} !== {e0 != 6'd0, e1 != 6'd0, e2 != 6'd0}) begin
      failed++;
      $display("FAIL %s margin: got %0d/%0d/%0d rdy=%b%b%b, expected %0d/%0d/%0d",
               name, ch0_margin, ch1_margin, ch2_margin, ch0_ready, ch1_ready, ch2_ready, e0, e1, e2);
    end
    if (mcdt_val === 1'b1) strobes_any++;
    if (mcdt_val === 1'b1 && mcdt_id === 2'd0) strobes0++;
    if (ch0_margin === 6'd0 && ch0_ready === 1'b0) saw_full = 1'b1;
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    {ch0_valid, ch1_valid, ch2_valid} = 3'b000;
    q0.delete();
    q1.delete();
    q2.delete();
    m_last = 2;
    m_val  = 1'b0;
    m_id   = 2'd0;
    m_data = 32'd0;
    repeat (n) @(posedge clk);
    #1;
    check_model("reset");
    rstn = 1'b1;
  endtask

  task automatic cycle(input string name, input logic [2:0] v, input logic [31:0] d0, d1, d2);
    bit acc0, acc1, acc2;
    int g;
    {ch2_valid, ch1_valid, ch0_valid} = v;
    ch0_data = d0;
    ch1_data = d1;
    ch2_data = d2;
    acc0 = v[0] && (q0.size() < 32);
    acc1 = v[1] && (q1.size() < 32);
    acc2 = v[2] && (q2.size() < 32);
    g = -1;
    for (int k = 1; k <= 3; k++) begin
      if (g < 0 && qsize((m_last + k) % 3) > 0) g = (m_last + k) % 3;
    end
    if (g >= 0) begin
      m_data = qpop(g);
      m_id   = 2'(g);
      m_val  = 1'b1;
      m_last = g;
    end else begin
      m_val  = 1'b0;
    end
    if (acc0) q0.push_back(d0);
    if (acc1) q1.push_back(d1);
    if (acc2) q2.push_back(d2);
    @(posedge clk);
    #1;
    check_model(name);
  endtask

  localparam logic [31:0] A0 = 32'hA000_0000, B0 = 32'hB000_0000, C0 = 32'hC000_0000;
  localparam logic [31:0] XW = 32'h1234_5678, YW = 32'h9ABC_DEF0, ZW = 32'h0F0F_0F0F;

  initial begin
    rstn = 1'b0;
    {ch0_valid, ch1_valid, ch2_valid} = 3'b000;
    ch0_data = 32'd0;
    ch1_data = 32'd0;
    ch2_data = 32'd0;

    // Reset held for 10 cycles
    do_reset(10);

    tbl[0]  = '{3'b111, A0,      B0,      C0,      1'b0, 2'd0, 32'd0,   6'd31, 6'd31, 6'd31};
    tbl[1]  = '{3'b111, A0 + 1,  B0 + 1,  C0 + 1,  1'b1, 2'd0, A0,      6'd31, 6'd30, 6'd30};
    tbl[2]  = '{3'b000, 32'd0,   32'd0,   32'd0,   1'b1, 2'd1, B0,      6'd31, 6'd31, 6'd30};
    tbl[3]  = '{3'b000, 32'd0,   32'd0,   32'd0,   1'b1, 2'd2, C0,      6'd31, 6'd31, 6'd31};
    tbl[4]  = '{3'b000, 32'd0,   32'd0,   32'd0,   1'b1, 2'd0, A0 + 1,  6'd32, 6'd31, 6'd31};
    tbl[5]  = '{3'b000, 32'd0,   32'd0,   32'd0,   1'b1, 2'd1, B0 + 1,  6'd32, 6'd32, 6'd31};
    tbl[6]  = '{3'b000, 32'd0,   32'd0,   32'd0,   1'b1, 2'd2, C0 + 1,  6'd32, 6'd32, 6'd32};
    tbl[7]  = '{3'b000, 32'd0,   32'd0,   32'd0,   1'b0, 2'd2, C0 + 1,  6'd32, 6'd32, 6'd32};
    tbl[8]  = '{3'b010, 32'd0,   XW,      32'd0,   1'b0, 2'd2, C0 + 1,  6'd32, 6'd31, 6'd32};
    tbl[9]  = '{3'b000, 32'd0,   32'd0,   32'd0,   1'b1, 2'd1, XW,      6'd32, 6'd32, 6'd32};
    tbl[10] = '{3'b101, ZW,      32'd0,   YW,      1'b0, 2'd1, XW,      6'd31, 6'd32, 6'd31};
    tbl[11] = '{3'b000, 32'd0,   32'd0,   32'd0,   1'b1, 2'd2, YW,      6'd31, 6'd32, 6'd32};
    tbl[12] = '{3'b000, 32'd0,   32'd0,   32'd0,   1'b1, 2'd0, ZW,      6'd32, 6'd32, 6'd32};

    // Round-robin order, hold behaviour, write-to-output latency, rotation after a ch1 grant
    for (int i = 0; i < 13; i++) begin
      {ch2_valid, ch1_valid, ch0_valid} = tbl[i].v;
      ch0_data = tbl[i].d0;
      ch1_data = tbl[i].d1;
      ch2_data = tbl[i].d2;
      @(posedge clk);
      #1;
      tests++;
      if (mcdt_val !== tbl[i].ev || mcdt_id !== tbl[i].eid || mcdt_data !== tbl[i].ed) begin
        failed++;
        $display("FAIL vec%0d out: got val=%0b id=%0d data=%h, expected val=%0b id=%0d data=%h",
                 i, mcdt_val, mcdt_id, mcdt_data, tbl[i].ev, tbl[i].eid, tbl[i].ed);
      end
      tests++;
      if ({ch0_margin, ch1_margin, ch2_margin} !== {tbl[i].m0, tbl[i].m1, tbl[i].m2}) begin
        failed++;
        $display("FAIL vec%0d margin: got %0d/%0d/%0d, expected %0d/%0d/%0d",
                 i, ch0_margin, ch1_margin, ch2_margin, tbl[i].m0, tbl[i].m1, tbl[i].m2);
      end
      tests++;
      if ({ch0_ready, ch1_ready, ch2_ready} !== 3'b111) begin
        failed++;
        $display("FAIL vec%0d ready: got %b%b%b, expected 111", i, ch0_ready, ch1_ready, ch2_ready);
      end
    end

    // Single-channel stream, one write every two cycles
    do_reset(2);
    strobes0 = 0;
    for (int i = 0; i < 100; i++) begin
      cycle("stream0", 3'b001, 32'(i), 32'd0, 32'd0);
      cycle("stream0", 3'b000, 32'd0, 32'd0, 32'd0);
    end
    tests++;
    if (strobes0 != 100) begin
      failed++;
      $display("FAIL stream0 count: got %0d strobes, expected 100", strobes0);
    end

    // Sequential channels 1 then 2
    for (int i = 0; i < 100; i++) cycle("seq1", 3'b010, 32'd0, 32'h1000_0000 + 32'(i), 32'd0);
    for (int i = 0; i < 100; i++) cycle("seq2", 3'b100, 32'd0, 32'd0, 32'h2000_0000 + 32'(i));
    repeat (3) cycle("seq_idle", 3'b000, 32'd0, 32'd0, 32'd0);

    // Continuous writes on all channels until FIFOs fill, then drain
    do_reset(1);
    saw_full = 1'b0;
    for (int n = 0; n < 120; n++) begin
      cycle("full", 3'b111, 32'hA100_0000 + 32'(n), 32'hB100_0000 + 32'(n), 32'hC100_0000 + 32'(n));
    end
    repeat (100) cycle("drain", 3'b000, 32'd0, 32'd0, 32'd0);
    tests++;
    if (!saw_full) begin
      failed++;
      $display("FAIL full: ch0 never reached margin=0/ready=0, expected it to");
    end

    // Reset mid-operation discards buffered words
    do_reset(1);
    for (int n = 0; n < 10; n++) begin
      cycle("prefill", 3'b111, 32'hA200_0000 + 32'(n), 32'hB200_0000 + 32'(n), 32'hC200_0000 + 32'(n));
    end
    do_reset(1);
    strobes_any = 0;
    repeat (20) cycle("post_reset", 3'b000, 32'd0, 32'd0, 32'd0);
    tests++;
    if (strobes_any != 0) begin
      failed++;
      $display("FAIL post_reset strobes: got %0d, expected 0", strobes_any);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
